// File: rtl/counter_chain_pkg.sv
// Shared types and helpers for the cascaded modulo counter.
// Provides the direction enum and the per-digit load clamp.
package counter_chain_pkg;

  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } dir_e;

  localparam int MAX_W = 4;

  // Digits at or above the modulus saturate to the largest legal digit.
  function automatic logic [MAX_W-1:0] clamp_digit(
    input logic [MAX_W-1:0] d,
    input int               modulus
  );
    if (32'(d) >= modulus) return MAX_W'(modulus - 1);
    return d;
  endfunction

endpackage

// File: rtl/counter_digit.sv
// One modulo-MODULUS digit stage: clear/load/step with wrap per digit.
// Ports: clk, rst, clear, load, load_digit, step, up -> digit, at_bound.
module counter_digit
  import counter_chain_pkg::*;
#(
  parameter int MODULUS = 10,
  parameter int W       = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_digit,
  input  logic         step,
  input  dir_e         up,
  output logic [W-1:0] digit,
  output logic         at_bound
);

  localparam logic [W-1:0] MAX = W'(MODULUS - 1);

  assign at_bound = (up == UP) ? (digit == MAX)
                               : (digit == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      digit <= '0;
    end else if (clear) begin
      digit <= '0;
    end else if (load) begin
      digit <= W'(clamp_digit(MAX_W'(load_digit), MODULUS));
    end else if (step) begin
      if (up == UP)
        digit <= at_bound ? '0 : digit + W'(1);
      else
        digit <= at_bound ? MAX : digit - W'(1);
    end
  end

endmodule

// File: rtl/counter_chain.sv
// Cascaded modulo counter: DIGITS stages, up/down, load, clear, wrap/saturate.
// Ports: clk, rst, enabled, up, clear, load, load_value -> value, carry, overflow.
module counter_chain
  import counter_chain_pkg::*;
#(
  parameter  int DIGITS  = 2,
  parameter  int MODULUS = 10,
  parameter  int WRAP    = 1,
  localparam int W       = (MODULUS < 3) ? 1 : $clog2(MODULUS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enabled,
  input  logic                     up,
  input  logic                     clear,
  input  logic                     load,
  input  logic [DIGITS-1:0][W-1:0] load_value,
  output logic [DIGITS-1:0][W-1:0] value,
  output logic                     carry,
  output logic                     overflow
);

  dir_e              dir;
  logic [DIGITS:0]   chain;
  logic [DIGITS-1:0] bound;
  logic              allow;

  assign dir      = dir_e'(up);
  assign chain[0] = enabled;
  assign carry    = chain[DIGITS];
  // In saturate mode a step that would roll the whole chain is dropped.
  assign allow    = (WRAP != 0) || !carry;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign chain[i+1] = chain[i] & bound[i];

    counter_digit #(
      .MODULUS (MODULUS),
      .W       (W)
    ) u_digit (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .load       (load),
      .load_digit (load_value[i]),
      .step       (chain[i] & allow),
      .up         (dir),
      .digit      (value[i]),
      .at_bound   (bound[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst || clear || load)
      overflow <= 1'b0;
    else
      overflow <= carry;
  end

endmodule
